// File: rtl/kernel_conv3x3_pkg.sv
// Shared beat-type encoding, 3x3 tap indexing and pipeline control payload
// for the row-buffer kernel stage and the 3x3 convolution stage.
package kernel_conv3x3_pkg;

    localparam int unsigned DTYPE_WIDTH = 8;

    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h02;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h04;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h08;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 8'h10;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 8'h40;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_LAST  = 8'h80;
    localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'hC0;

    localparam int unsigned KCONV_TAPS = 9;

    // Flat index of window tap (r,c); r0 is the oldest row, c0 the oldest column.
    function automatic int unsigned kconv_idx(input int unsigned r, input int unsigned c);
        return 3 * r + c;
    endfunction

    typedef struct packed {
        logic                   valid;
        logic                   pixel;
        logic                   filt_en;
        logic [DTYPE_WIDTH-1:0] dtype;
    } beat_ctl_t;

endpackage

// File: rtl/kernel_conv3x3_row_sum.sv
// One kernel row: three signed pixel x coefficient products (registered),
// then their registered sum with two guard bits.
module conv_row_sum #(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned COEF_WIDTH  = 8
) (
    input  logic                                       clk,
    input  logic                                       resetb,
    input  logic        [3*PIXEL_WIDTH-1:0]            pix,
    input  logic        [3*COEF_WIDTH-1:0]             coef,
    output logic signed [PIXEL_WIDTH+COEF_WIDTH+2:0]   row_sum
);

    localparam int unsigned PROD_W = PIXEL_WIDTH + 1 + COEF_WIDTH;
    localparam int unsigned ROW_W  = PROD_W + 2;

    logic signed [PROD_W-1:0] prod_q [3];

    // Pixels are unsigned; a zero MSB makes them non-negative signed operands.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 3; i++) prod_q[i] <= '0;
            row_sum <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                prod_q[i] <= PROD_W'($signed({1'b0, pix[i*PIXEL_WIDTH +: PIXEL_WIDTH]}))
                           * PROD_W'($signed(coef[i*COEF_WIDTH +: COEF_WIDTH]));
            end
            row_sum <= ROW_W'(prod_q[0]) + ROW_W'(prod_q[1]) + ROW_W'(prod_q[2]);
        end
    end

endmodule

// File: rtl/kernel_conv3x3.sv
// Programmable 3x3 convolution with fixed 3-clk latency for every beat type.
// Define KERNEL_CONV_ROUND_EN to round half up before the post-sum shift.
module kernel_conv3x3
    import kernel_conv3x3_pkg::*;
#(
    parameter int unsigned PIXEL_WIDTH = 10,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COEF_WIDTH  = 8,
    parameter int unsigned SHIFT_WIDTH = 4
) (
    input  logic                                clk,
    input  logic                                resetb,
    input  logic                                dvi,
    input  logic [DTYPE_WIDTH-1:0]              dtypei,
    input  logic [DATA_WIDTH-1:0]               meta_datai,
    input  logic [KCONV_TAPS*PIXEL_WIDTH-1:0]   kernel_datai,
    input  logic                                enable,
    input  logic [KCONV_TAPS*COEF_WIDTH-1:0]    coef_i,
    input  logic [SHIFT_WIDTH-1:0]              shift_i,
    output logic                                dvo,
    output logic [DTYPE_WIDTH-1:0]              dtypeo,
    output logic [DATA_WIDTH-1:0]               datao
);

    localparam int unsigned ROW_W  = PIXEL_WIDTH + COEF_WIDTH + 3;
    localparam int unsigned ACC_W  = PIXEL_WIDTH + COEF_WIDTH + 5;
    localparam int unsigned CENTRE = kconv_idx(1, 1);
    localparam logic [KCONV_TAPS*COEF_WIDTH-1:0] COEF_IDENTITY =
        (KCONV_TAPS*COEF_WIDTH)'(1) << (CENTRE * COEF_WIDTH);

    logic [KCONV_TAPS*COEF_WIDTH-1:0] coef_act;
    logic [SHIFT_WIDTH-1:0]           shift_act;
    logic                             enable_act;

    logic                             frame_start;
    logic [KCONV_TAPS*COEF_WIDTH-1:0] coef_use;
    logic [SHIFT_WIDTH-1:0]           shift_use;
    logic                             enable_use;

    // A frame-start beat already uses the settings it latches.
    assign frame_start = dvi && (dtypei == DTYPE_FRAME_START);
    assign coef_use    = frame_start ? coef_i  : coef_act;
    assign shift_use   = frame_start ? shift_i : shift_act;
    assign enable_use  = frame_start ? enable  : enable_act;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            coef_act   <= COEF_IDENTITY;
            shift_act  <= '0;
            enable_act <= 1'b1;
        end else if (frame_start) begin
            coef_act   <= coef_i;
            shift_act  <= shift_i;
            enable_act <= enable;
        end
    end

    // Per-beat side information travels with the beat so settings stay aligned.
    beat_ctl_t              ctl_in;
    beat_ctl_t              ctl_q    [2];
    logic [DATA_WIDTH-1:0]  meta_q   [2];
    logic [PIXEL_WIDTH-1:0] centre_q [2];
    logic [SHIFT_WIDTH-1:0] shift_q  [2];

    always_comb begin
        ctl_in.valid   = dvi;
        ctl_in.pixel   = dvi && (|(dtypei & DTYPE_PIXEL_MASK));
        ctl_in.filt_en = enable_use;
        ctl_in.dtype   = dtypei;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < 2; i++) begin
                ctl_q[i]    <= '0;
                meta_q[i]   <= '0;
                centre_q[i] <= '0;
                shift_q[i]  <= '0;
            end
        end else begin
            ctl_q[0]    <= ctl_in;
            meta_q[0]   <= meta_datai;
            centre_q[0] <= kernel_datai[CENTRE*PIXEL_WIDTH +: PIXEL_WIDTH];
            shift_q[0]  <= shift_use;
            ctl_q[1]    <= ctl_q[0];
            meta_q[1]   <= meta_q[0];
            centre_q[1] <= centre_q[0];
            shift_q[1]  <= shift_q[0];
        end
    end

    logic signed [ROW_W-1:0] row_sum [3];

    for (genvar r = 0; r < 3; r++) begin : g_row
        conv_row_sum #(
            .PIXEL_WIDTH (PIXEL_WIDTH),
            .COEF_WIDTH  (COEF_WIDTH)
        ) u_row (
            .clk     (clk),
            .resetb  (resetb),
            .pix     (kernel_datai[kconv_idx(r, 0)*PIXEL_WIDTH +: 3*PIXEL_WIDTH]),
            .coef    (coef_use[kconv_idx(r, 0)*COEF_WIDTH +: 3*COEF_WIDTH]),
            .row_sum (row_sum[r])
        );
    end

    logic signed [ACC_W-1:0]  total;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic [PIXEL_WIDTH-1:0]   clamped;

    // S3: total, optional rounding, arithmetic shift, clamp to pixel range.
    always_comb begin
        total   = ACC_W'(row_sum[0]) + ACC_W'(row_sum[1]) + ACC_W'(row_sum[2]);
        rounded = total;
`ifdef KERNEL_CONV_ROUND_EN
        if (shift_q[1] != '0) begin
            rounded = total + (ACC_W'(1) << (shift_q[1] - SHIFT_WIDTH'(1)));
        end
`endif
        shifted = rounded >>> shift_q[1];
        clamped = shifted[PIXEL_WIDTH-1:0];
        if (shifted[ACC_W-1]) begin
            clamped = '0;
        end else if (|shifted[ACC_W-2:PIXEL_WIDTH]) begin
            clamped = '1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            dvo    <= 1'b0;
            dtypeo <= '0;
            datao  <= '0;
        end else begin
            dvo    <= ctl_q[1].valid;
            dtypeo <= ctl_q[1].dtype;
            if (ctl_q[1].pixel) begin
                datao <= ctl_q[1].filt_en ? DATA_WIDTH'(clamped) : DATA_WIDTH'(centre_q[1]);
            end else begin
                datao <= meta_q[1];
            end
        end
    end

endmodule

// File: tb/tb_kernel_conv3x3.sv
// Self-checking bench for kernel_conv3x3: directed vector table, hand-written
// frame/reset sequences and randomized beats against a behavioural model.
module tb_kernel_conv3x3;
    import kernel_conv3x3_pkg::*;

    localparam int unsigned PW = 10;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned SW = 4;

    logic                  clk;
    logic                  resetb;
    logic                  dvi;
    logic [DTYPE_WIDTH-1:0] dtypei;
    logic [DW-1:0]         meta_datai;
    logic [9*PW-1:0]       kernel_datai;
    logic                  enable;
    logic [9*CW-1:0]       coef_i;
    logic [SW-1:0]         shift_i;
    logic                  dvo;
    logic [DTYPE_WIDTH-1:0] dtypeo;
    logic [DW-1:0]         datao;

    kernel_conv3x3 #(
        .PIXEL_WIDTH (PW),
        .DATA_WIDTH  (DW),
        .COEF_WIDTH  (CW),
        .SHIFT_WIDTH (SW)
    ) dut (
        .clk          (clk),
        .resetb       (resetb),
        .dvi          (dvi),
        .dtypei       (dtypei),
        .meta_datai   (meta_datai),
        .kernel_datai (kernel_datai),
        .enable       (enable),
        .coef_i       (coef_i),
        .shift_i      (shift_i),
        .dvo          (dvo),
        .dtypeo       (dtypeo),
        .datao        (datao)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                     dvi;
        logic [DTYPE_WIDTH-1:0] dtype;
        logic [DW-1:0]          meta;
        logic [9*PW-1:0]        win;
        logic [9*CW-1:0]        coef;
        logic [SW-1:0]          shift;
        bit                     en;
    } in_t;

    typedef struct {
        bit                     dvo;
        logic [DTYPE_WIDTH-1:0] dtype;
        logic [DW-1:0]          data;
        int                     tbl;
    } exp_t;

    typedef struct {
        bit fs;
        int po, pc, co, cc, sh;
        bit en;
        int exp;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   ncyc  = 0;
    exp_t sb [$];

    int act_coef [9];
    int act_shift;
    bit act_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, ncyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) act_coef[i] = 0;
        act_coef[kconv_idx(1, 1)] = 1;
        act_shift = 0;
        act_en    = 1'b1;
    endtask

    // Expected output for one input beat, straight from the filter definition.
    task automatic model(input in_t x, output exp_t e);
        int sum;
        int res;
        if (x.dvi && x.dtype == DTYPE_FRAME_START) begin
            for (int i = 0; i < 9; i++) act_coef[i] = int'($signed(x.coef[i*CW +: CW]));
            act_shift = int'(x.shift);
            act_en    = x.en;
        end
        e.dvo   = x.dvi;
        e.dtype = x.dtype;
        e.tbl   = -1;
        if (x.dvi && (x.dtype & DTYPE_PIXEL_MASK) != 0) begin
            if (!act_en) begin
                e.data = DW'(x.win[kconv_idx(1, 1)*PW +: PW]);
            end else begin
                sum = 0;
                for (int i = 0; i < 9; i++) sum += int'(x.win[i*PW +: PW]) * act_coef[i];
`ifdef KERNEL_CONV_ROUND_EN
                if (act_shift > 0) sum += 1 << (act_shift - 1);
`endif
                res = sum >>> act_shift;
                if (res < 0) res = 0;
                if (res > 1023) res = 1023;
                e.data = DW'(res);
            end
        end else begin
            e.data = x.meta;
        end
    endtask

    function automatic in_t mk(bit v, logic [DTYPE_WIDTH-1:0] dt, logic [DW-1:0] meta,
                               int po, int pc, int co, int cc, int sh, bit en);
        in_t x;
        x.dvi = v; x.dtype = dt; x.meta = meta; x.shift = SW'(sh); x.en = en;
        for (int i = 0; i < 9; i++) begin
            x.win[i*PW +: PW]  = PW'((i == 4) ? pc : po);
            x.coef[i*CW +: CW] = CW'((i == 4) ? cc : co);
        end
        return x;
    endfunction

    function automatic in_t rnd();
        in_t x;
        x.dvi  = ($urandom_range(0, 3) != 0);
        x.meta = DW'($urandom);
        case ($urandom_range(0, 11))
            0:       x.dtype = DTYPE_FRAME_START;
            1:       x.dtype = DTYPE_FRAME_END;
            2:       x.dtype = DTYPE_ROW_START;
            3:       x.dtype = DTYPE_ROW_END;
            4:       x.dtype = DTYPE_HEADER;
            5:       x.dtype = DTYPE_PIXEL_LAST;
            default: x.dtype = DTYPE_PIXEL;
        endcase
        for (int i = 0; i < 9; i++) begin
            x.win[i*PW +: PW]  = PW'($urandom);
            x.coef[i*CW +: CW] = ($urandom_range(0, 3) == 0) ? CW'($urandom) : CW'($urandom_range(0, 40) - 8);
        end
        x.shift = SW'($urandom_range(0, 15));
        x.en    = ($urandom_range(0, 4) != 0);
        return x;
    endfunction

    // Apply one beat, advance one clock, compare the beat issued 3 clocks earlier.
    task automatic cycle(input in_t x, input int tbl);
        exp_t e;
        dvi          = x.dvi;
        dtypei       = x.dtype;
        meta_datai   = x.meta;
        kernel_datai = x.win;
        coef_i       = x.coef;
        shift_i      = x.shift;
        enable       = x.en;
        model(x, e);
        e.tbl = tbl;
        sb.push_back(e);
        @(posedge clk);
        #1;
        ncyc++;
        if (sb.size() == 3) begin
            e = sb.pop_front();
            check("dvo", 32'(dvo), 32'(e.dvo));
            if (e.dvo) begin
                check("dtypeo", 32'(dtypeo), 32'(e.dtype));
                check("datao", 32'(datao), 32'(e.data));
                if (e.tbl >= 0) check("table_datao", 32'(datao), e.tbl);
            end
        end
    endtask

    // Pipeline restarts empty: the first two outputs after release are bubbles.
    task automatic after_release();
        exp_t b;
        b.dvo = 1'b0; b.dtype = '0; b.data = '0; b.tbl = -1;
        model_reset();
        sb.delete();
        sb.push_back(b);
        sb.push_back(b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [10];
        tbl[0] = '{0, 100,  500,    1,    1,  3, 1, 500};
        tbl[1] = '{1,   8,    8,    1,    1,  3, 1,   9};
        tbl[2] = '{1, 1023,   0,   -1,    9,  0, 1,   0};
        tbl[3] = '{1,   0, 1000,    0,    2,  0, 1, 1023};
`ifdef KERNEL_CONV_ROUND_EN
        tbl[4] = '{1,   1,    1,    1,    4,  3, 1,   2};
        tbl[8] = '{1, 1023, 1023, 127,  127, 15, 1,  36};
`else
        tbl[4] = '{1,   1,    1,    1,    4,  3, 1,   1};
        tbl[8] = '{1, 1023, 1023, 127,  127, 15, 1,  35};
`endif
        tbl[5] = '{1,   5,   77,    1,    1,  3, 0,  77};
        tbl[6] = '{1,  50,   60,   -1,    8,  0, 1,  80};
        tbl[7] = '{1,   0,    3,    0,   -1, 15, 1,   0};
        tbl[9] = '{1, 1023, 1023, -128, -128, 0, 1,   0};

        resetb = 1'b0;
        dvi = 1'b0; dtypei = '0; meta_datai = '0; kernel_datai = '0;
        enable = 1'b0; coef_i = '0; shift_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dvo", 32'(dvo), 32'd0);
        check("reset_dtypeo", 32'(dtypeo), 32'd0);
        check("reset_datao", 32'(datao), 32'd0);
        resetb = 1'b1;
        after_release();

        // Directed vectors: optional frame start, one pixel beat, one bubble.
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].fs)
                cycle(mk(1, DTYPE_FRAME_START, DW'(16'h0F00 + i), 0, 0,
                         tbl[i].co, tbl[i].cc, tbl[i].sh, tbl[i].en), -1);
            cycle(mk(1, DTYPE_PIXEL, '0, tbl[i].po, tbl[i].pc,
                     tbl[i].co, tbl[i].cc, tbl[i].sh, tbl[i].en), tbl[i].exp);
            cycle(mk(0, DTYPE_PIXEL, '0, 0, 0, 0, 0, 0, 1), -1);
        end

        // Mid-frame coefficient change is ignored until the next frame start.
        cycle(mk(1, DTYPE_FRAME_START, 16'h1234, 0, 0, 1, 1, 3, 1), -1);
        cycle(mk(1, DTYPE_PIXEL,       16'h0000, 8, 8, 1, 1, 3, 1),  9);
        cycle(mk(1, DTYPE_PIXEL,       16'h0000, 8, 8, 0, 1, 0, 1),  9);
        cycle(mk(1, DTYPE_ROW_END,     16'hBEEF, 8, 8, 0, 1, 0, 1), -1);
        cycle(mk(0, DTYPE_FRAME_START, 16'h0000, 8, 8, 0, 1, 0, 1), -1);
        cycle(mk(1, DTYPE_PIXEL_LAST,  16'h0000, 8, 8, 0, 1, 0, 1),  9);
        cycle(mk(1, DTYPE_FRAME_START, 16'h4321, 8, 8, 0, 1, 0, 1), -1);
        cycle(mk(1, DTYPE_PIXEL,       16'h0000, 8, 8, 1, 1, 3, 1),  8);
        cycle(mk(1, DTYPE_FRAME_START, 16'h5555, 0, 0, 1, 1, 3, 0), -1);
        cycle(mk(1, DTYPE_PIXEL,       16'h0000, 8, 33, 1, 1, 3, 1), 33);

        // Randomized interleaved markers, pixels, gaps and frame starts.
        for (int i = 0; i < 400; i++) cycle(rnd(), -1);

        // Reset asserted mid-row with valid beats in flight.
        cycle(mk(1, DTYPE_ROW_START, 16'hA5A5, 0, 0, 1, 1, 3, 1), -1);
        cycle(mk(1, DTYPE_PIXEL,     16'h0000, 4, 9, 1, 1, 3, 1), -1);
        cycle(mk(1, DTYPE_PIXEL,     16'h0000, 6, 2, 1, 1, 3, 1), -1);
        resetb = 1'b0;
        #1;
        check("midreset_dvo", 32'(dvo), 32'd0);
        check("midreset_dtypeo", 32'(dtypeo), 32'd0);
        check("midreset_datao", 32'(datao), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        check("midreset_hold_dvo", 32'(dvo), 32'd0);
        resetb = 1'b1;
        after_release();
        cycle(mk(1, DTYPE_PIXEL, 16'h0000, 7, 21, 1, 1, 3, 1), 21);
        cycle(mk(1, DTYPE_HEADER, 16'hC0DE, 0, 0, 1, 1, 3, 1), -1);

        for (int i = 0; i < 3; i++) cycle(mk(0, DTYPE_HEADER, '0, 0, 0, 0, 0, 0, 1), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
